// File: rtl/muxn_rr_if.sv
// Channel-input and registered-output handshake bundle for muxn_rr.
// The mux itself connects through the slave modport; the driving environment uses master.
interface muxn_rr_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic [SELW-1:0]      out_ch;
    logic                 out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/muxn_rr.sv
// N-channel registered multiplexer with fixed-select or round-robin arbitration.
// A single output register stage; in_ready is the combinational grant of the current cycle.
module muxn_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [15:0]     xfer_cnt,
    muxn_rr_if.slave        bus
);
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  fix_ch, hi_ch, low_ch, grant_ch, ptr_next;
    logic             fix_hit, hi_hit, low_hit, cand_hit;
    logic             load, grant;
    logic [WIDTH-1:0] grant_data;

    // The output register can take a new word when empty or being drained this cycle.
    assign load = !bus.out_valid || bus.out_ready;

    // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        fix_ch   = '0;
        fix_hit  = 1'b0;
        hi_ch    = '0;
        hi_hit   = 1'b0;
        low_ch   = '0;
        low_hit  = 1'b0;
        cand_hit = 1'b0;
        grant_ch = '0;
        // Descending scan leaves the lowest match; hi_* only sees channels at or above ptr.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (bus.in_valid[k]) begin
                low_hit = 1'b1;
                low_ch  = SELW'(k);
            end
            if (bus.in_valid[k] && (SELW'(k) >= ptr)) begin
                hi_hit = 1'b1;
                hi_ch  = SELW'(k);
            end
            if (bus.in_valid[k] && (SELW'(k) == sel)) begin
                fix_hit = 1'b1;
                fix_ch  = sel;
            end
        end
        if (mode) begin
            cand_hit = low_hit;
            grant_ch = hi_hit ? hi_ch : low_ch;
        end else begin
            cand_hit = fix_hit;
            grant_ch = fix_ch;
        end
    end

    assign grant    = rst_n && load && cand_hit;
    assign ptr_next = (grant_ch == SELW'(NCH - 1)) ? '0 : grant_ch + SELW'(1);

    always_comb begin
        bus.in_ready = '0;
        grant_data   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant_ch == SELW'(k)) begin
                bus.in_ready[k] = grant;
                grant_data      = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= '0;
            xfer_cnt      <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
            if (grant) begin
                bus.out_data  <= grant_data;
                bus.out_ch    <= grant_ch;
                bus.out_valid <= 1'b1;
                if (mode) begin
                    ptr <= ptr_next;
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_muxn_rr.sv
// Self-checking bench for muxn_rr: reset/fixed/round-robin vector table, backpressure and
// mid-operation reset sequences, a 3-channel instance for out-of-range select, and random traffic.
module tb_muxn_rr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [15:0] xfer_cnt;
    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = 2'd0;
    logic [15:0] xfer_cnt3;

    muxn_rr_if #(.WIDTH(8), .NCH(4), .SELW(2)) bus ();
    muxn_rr_if #(.WIDTH(8), .NCH(3), .SELW(2)) bus3 ();

    muxn_rr #(.WIDTH(8), .NCH(4), .SELW(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .xfer_cnt(xfer_cnt), .bus(bus)
    );
    muxn_rr #(.WIDTH(8), .NCH(3), .SELW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .xfer_cnt(xfer_cnt3), .bus(bus3)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state of the output register, arbitration pointer and transfer count.
    logic        m_valid = 1'b0;
    logic [7:0]  m_data = 8'h00;
    int          m_ch = 0;
    int          m_ptr = 0;
    logic [15:0] m_cnt = 16'd0;
    logic [3:0]  last_rdy;

    function automatic int model_grant(input logic rn, input logic md, input logic [1:0] s,
                                       input logic [3:0] v, input logic ordy);
        if (!rn) return -1;
        if (m_valid && !ordy) return -1;
        if (!md) return v[s] ? int'(s) : -1;
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (m_ptr + i) % 4;
            if (v[2'(c)]) return c;
        end
        return -1;
    endfunction

    // One cycle: drive at negedge, check in_ready, clock, advance the model, check outputs.
    task automatic step(input logic rn, input logic md, input logic [1:0] s, input logic [3:0] v,
                        input logic [31:0] d, input logic ordy);
        int g;
        @(negedge clk);
        rst_n = rn; mode = md; sel = s;
        bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy;
        #1;
        g = model_grant(rn, md, s, v, ordy);
        last_rdy = bus.in_ready;
        check("in_ready", 32'(bus.in_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        @(posedge clk);
        if (!rn) begin
            m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = 0; m_cnt = 16'd0;
        end else begin
            if (m_valid && ordy) m_cnt = m_cnt + 16'd1;
            if (g >= 0) begin
                m_data  = 8'(d >> (8 * g));
                m_ch    = g;
                m_valid = 1'b1;
                if (md) m_ptr = (g + 1) % 4;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_data", 32'(bus.out_data), 32'(m_data));
        check("out_ch", 32'(bus.out_ch), 32'(m_ch));
        check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
    endtask

    typedef struct {
        logic        rn;
        logic        md;
        logic [1:0]  sel;
        logic [3:0]  v;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  ch;
        logic [7:0]  data;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic rn, input logic md, input logic [1:0] s,
                                input logic [3:0] v, input logic ordy, input logic [3:0] rdy,
                                input logic ov, input logic [1:0] ch, input logic [7:0] data,
                                input logic [15:0] cnt);
        vec_t r;
        r.rn = rn; r.md = md; r.sel = s; r.v = v; r.ordy = ordy;
        r.rdy = rdy; r.ov = ov; r.ch = ch; r.data = data; r.cnt = cnt;
        return r;
    endfunction

    localparam logic [31:0] D0 = 32'hDD_A5_BB_CC;
    vec_t vecs[15];

    initial begin
        bus.in_valid = 4'h0; bus.in_data = '0; bus.out_ready = 1'b1;
        bus3.in_valid = 3'h0; bus3.in_data = '0; bus3.out_ready = 1'b1;

        // Hand-derived expectations, channel data ch3..ch0 = DD A5 BB CC.
        vecs[0]  = mk(0, 1, 2'd0, 4'hF, 1, 4'b0000, 0, 2'd0, 8'h00, 16'd0);
        vecs[1]  = mk(0, 1, 2'd0, 4'hF, 1, 4'b0000, 0, 2'd0, 8'h00, 16'd0);
        vecs[2]  = mk(1, 1, 2'd0, 4'hF, 1, 4'b0001, 1, 2'd0, 8'hCC, 16'd0);
        vecs[3]  = mk(1, 1, 2'd0, 4'hF, 1, 4'b0010, 1, 2'd1, 8'hBB, 16'd1);
        vecs[4]  = mk(1, 1, 2'd0, 4'hF, 1, 4'b0100, 1, 2'd2, 8'hA5, 16'd2);
        vecs[5]  = mk(1, 1, 2'd0, 4'hF, 1, 4'b1000, 1, 2'd3, 8'hDD, 16'd3);
        vecs[6]  = mk(1, 1, 2'd0, 4'hF, 1, 4'b0001, 1, 2'd0, 8'hCC, 16'd4);
        vecs[7]  = mk(1, 0, 2'd2, 4'hF, 1, 4'b0100, 1, 2'd2, 8'hA5, 16'd5);
        vecs[8]  = mk(1, 1, 2'd0, 4'h9, 1, 4'b1000, 1, 2'd3, 8'hDD, 16'd6);
        vecs[9]  = mk(1, 1, 2'd0, 4'h9, 1, 4'b0001, 1, 2'd0, 8'hCC, 16'd7);
        vecs[10] = mk(1, 1, 2'd0, 4'h9, 1, 4'b1000, 1, 2'd3, 8'hDD, 16'd8);
        vecs[11] = mk(1, 1, 2'd0, 4'h9, 1, 4'b0001, 1, 2'd0, 8'hCC, 16'd9);
        vecs[12] = mk(1, 1, 2'd0, 4'h0, 1, 4'b0000, 0, 2'd0, 8'hCC, 16'd10);
        vecs[13] = mk(1, 1, 2'd0, 4'h0, 0, 4'b0000, 0, 2'd0, 8'hCC, 16'd10);
        vecs[14] = mk(1, 0, 2'd1, 4'hD, 1, 4'b0000, 0, 2'd0, 8'hCC, 16'd10);

        foreach (vecs[i]) begin
            step(vecs[i].rn, vecs[i].md, vecs[i].sel, vecs[i].v, D0, vecs[i].ordy);
            check($sformatf("vec%0d_rdy", i), 32'(last_rdy), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_ov", i), 32'(bus.out_valid), 32'(vecs[i].ov));
            check($sformatf("vec%0d_ch", i), 32'(bus.out_ch), 32'(vecs[i].ch));
            check($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].data));
            check($sformatf("vec%0d_cnt", i), 32'(xfer_cnt), 32'(vecs[i].cnt));
        end

        // Backpressure: load channel 1 (ptr=1), stall three cycles with changing inputs, then drain+load.
        step(1, 1, 2'd0, 4'hF, D0, 0);
        check("bp_load_ch", 32'(bus.out_ch), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 2'd0, 4'hF, $urandom, 0);
            check("bp_hold_rdy", 32'(last_rdy), 32'd0);
            check("bp_hold_data", 32'(bus.out_data), 32'hBB);
        end
        step(1, 1, 2'd0, 4'hF, 32'h44_33_22_11, 1);
        check("bp_drain_rdy", 32'(last_rdy), 32'b0100);
        check("bp_drain_data", 32'(bus.out_data), 32'h33);
        check("bp_drain_ov", 32'(bus.out_valid), 32'd1);

        // Reset mid-operation: ptr=3 -> grant ch1 leaves ptr=2, stall, reset, then first RR grant is ch0.
        step(1, 1, 2'd0, 4'b0010, D0, 1);
        step(1, 1, 2'd0, 4'hF, D0, 0);
        step(0, 1, 2'd0, 4'hF, D0, 0);
        check("rst_ov", 32'(bus.out_valid), 32'd0);
        check("rst_cnt", 32'(xfer_cnt), 32'd0);
        step(1, 1, 2'd0, 4'hF, D0, 1);
        check("rst_first_grant", 32'(last_rdy), 32'b0001);
        check("rst_first_ch", 32'(bus.out_ch), 32'd0);

        // Park the 4-channel DUT (holds under backpressure or stays empty) while exercising NCH=3.
        @(negedge clk);
        bus.in_valid = 4'h0; bus.out_ready = 1'b0;
        mode3 = 1'b0; sel3 = 2'd3; bus3.in_valid = 3'b111; bus3.in_data = 24'h33_22_11;
        #1;
        check("n3_sel_oob_rdy", 32'(bus3.in_ready), 32'd0);
        @(posedge clk); #1;
        check("n3_sel_oob_ov", 32'(bus3.out_valid), 32'd0);
        @(negedge clk);
        sel3 = 2'd2;
        #1;
        check("n3_sel2_rdy", 32'(bus3.in_ready), 32'b100);
        @(posedge clk); #1;
        check("n3_sel2_data", 32'(bus3.out_data), 32'h33);
        for (int i = 0; i < 4; i++) begin
            int exp_ch;
            exp_ch = i % 3;
            @(negedge clk);
            mode3 = 1'b1;
            #1;
            check("n3_rr_rdy", 32'(bus3.in_ready), 32'd1 << exp_ch);
            @(posedge clk); #1;
            check("n3_rr_ch", 32'(bus3.out_ch), 32'(exp_ch));
        end
        check("n3_cnt", 32'(xfer_cnt3), 32'd4);
        check("park_ov", 32'(bus.out_valid), 32'(m_valid));
        check("park_cnt", 32'(xfer_cnt), 32'(m_cnt));

        // Random traffic with occasional reset, mode/sel churn and backpressure.
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 40) != 0, 1'($urandom), 2'($urandom), 4'($urandom),
                 $urandom, ($urandom % 4) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muxn_rr.md
MUXN_RR -- requirements
Module: muxn_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width per channel.
REQ-002 SHALL have parameter NCH, default 4: channel count, range 2..16.
REQ-003 SHALL have parameter SELW, default 2: select and pointer width; SHALL satisfy 2^SELW >= NCH.
REQ-004 SHALL have one clock and one reset: `clk` and `rst_n`.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port mode, input, 1 bit: 0 = fixed select, 1 = round-robin.
REQ-008 SHALL have port sel, input, SELW bits: channel index used in fixed mode.
REQ-009 SHALL have port in_data, input, NCH*WIDTH bits: channel k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port in_valid, input, NCH bits: per-channel data valid.
REQ-011 SHALL have port in_ready, output, NCH bits: per-channel accept, at most one bit high.
REQ-012 SHALL have port out_data, output, WIDTH bits: registered selected data.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data holds an unconsumed word.
REQ-014 SHALL have port out_ch, output, SELW bits: source channel of out_data.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-016 SHALL have port xfer_cnt, output, 16 bits: count of completed output transfers.

Function
REQ-017 SHALL define load = !out_valid || out_ready, evaluated combinationally each cycle.
REQ-018 In fixed mode, the candidate SHALL be sel; a grant occurs when load && in_valid[sel] && sel < NCH.
REQ-019 If sel >= NCH, there SHALL be no grant and in_ready SHALL be all zero.
REQ-020 In round-robin mode, the candidate SHALL be the first channel with in_valid set, searching upward from pointer ptr and wrapping NCH-1 -> 0.
REQ-021 In round-robin mode, a grant SHALL occur when load is high and any in_valid bit is set.
REQ-022 in_ready[g] SHALL be high, combinationally, only for the granted channel g; all other bits SHALL be 0.
REQ-023 On a grant, the next edge SHALL capture out_data = in_data channel g, out_ch = g and out_valid = 1; latency SHALL be 1 cycle.
REQ-024 On a round-robin grant, ptr SHALL become (g+1) mod NCH.
REQ-025 On a fixed-mode grant, or when there is no grant, ptr SHALL hold its value.
REQ-026 If out_valid && out_ready with no grant, out_valid SHALL become 0.
REQ-027 out_data and out_ch SHALL hold their last value whenever no grant occurs.
REQ-028 If out_valid && !out_ready, out_data, out_ch and out_valid SHALL hold, and in_ready SHALL be all zero.
REQ-029 A simultaneous drain (out_valid && out_ready) and grant SHALL load the new word in the same edge, with no bubble.
REQ-030 A change of mode or sel SHALL affect only the combinational grant of the current cycle; already-registered output SHALL be unaffected.
REQ-031 xfer_cnt SHALL increment by 1 on each edge where out_valid && out_ready, and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-032 When rst_n = 0 at a rising edge: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, xfer_cnt = 0.
REQ-033 Reset SHALL override any grant or transfer in the same cycle; a word held in the output register is discarded.
REQ-034 While rst_n = 0, in_ready SHALL be all zero.

Verification (NCH=4, WIDTH=8)
REQ-035 Reset: rst_n=0 for 2 cycles, in_valid=4'hF, out_ready=1 -> in_ready=0, out_valid=0, xfer_cnt=0.
REQ-036 Fixed mode: mode=0, sel=2, channel 2 data=8'hA5, in_valid=4'hF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_ch=2, out_valid=1.
REQ-037 Round-robin, all valid: mode=1, in_valid=4'hF, out_ready=1 for 5 cycles from reset -> out_ch sequence 0,1,2,3,0; xfer_cnt=4 after the 5th edge.
REQ-038 Round-robin, sparse: in_valid=4'b1001, ptr=1 -> grants 3, 0, 3, 0.
REQ-039 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data constant and in_ready=0; out_ready=1 -> next word loaded on the same edge as the drain.
REQ-040 Reset mid-operation: out_valid=1, out_ready=0, ptr=2, then rst_n=0 for 1 edge -> out_valid=0, ptr=0; first round-robin grant after release is channel 0.
